regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Shares the single write port of the 16-entry × 64-bit register file between two writeback requesters (ALU pipe A, memory/load pipe M) with round-robin arbitration and one registered output stage. It also holds a 16-bit pending-write scoreboard: the issue stage reserves a destination register before dispatch, and the register is released when its write commits. It sits between the execute/memory writeback buses and the register file's `waddr`/`wdata`/`wea` port, and drives the issue stage's stall condition.

## Interface
- `DW`, 64, write data width
- `AW`, 4, register address width; 2^AW registers tracked
- `clk` in 1, clock
- `reset` in 1, synchronous, active-high
- `a_valid` in 1, ALU pipe write request
- `a_rd` in AW, ALU destination register
- `a_data` in DW, ALU result
- `a_ready` out 1, ALU request accepted this cycle
- `m_valid`, `m_rd`, `m_data`, `m_ready`: same as the `a_*` ports, for the memory pipe
- `issue_valid` in 1, issue stage reserving a destination register
- `issue_rd` in AW, register to reserve
- `issue_ready` out 1, reservation accepted this cycle
- `pending` out 2^AW, scoreboard bit per register
- `rf_wea` out 1, register-file write enable
- `rf_waddr` out AW, register-file write address
- `rf_wdata` out DW, register-file write data
- `wb_err` out 1, sticky; set when a write is accepted for a register that is not pending
- `rd0_addr`, `rd1_addr` in AW, read addresses presented to the register file
- `rf_r0data`, `rf_r1data` in DW, raw register-file read data
- `fwd0_data`, `fwd1_data` out DW, read data after optional bypass

## Operation
- **Grant.** The grant is combinational from the valids and `last_grant` (1 bit, A=0, M=1).
  - One valid: that requester is granted.
  - Both valid: the requester not equal to `last_grant` is granted.
- **Handshake.**
  - `a_ready` = grant to A; `m_ready` = grant to M.
  - At most one ready is high per cycle. A ready is never high unless its valid is high.
  - A transfer occurs on valid & ready.
  - A requester that is not granted holds valid and its payload until accepted.
- **Pointer update.** `last_grant` updates only on a transfer.
- **Output stage.** The output stage never stalls, because the register file accepts a write every cycle.
  - On a transfer: `rf_wea`←1, and `rf_waddr`/`rf_wdata` ← the granted requester's rd/data.
  - Otherwise `rf_wea`←0, and addr/data hold their previous values.
- **Scoreboard.**
  - Reserve: on `issue_valid & issue_ready`, `pending[issue_rd]`←1.
  - Release: when `rf_wea` is high, `pending[rf_waddr]`←0.
  - `issue_ready` = !`pending[issue_rd]`. A register being released this cycle still reads as pending, so `issue_ready` stays low for it.
  - Set and clear of the same bit in one cycle cannot occur, because reservation requires the bit to be clear. If it is forced, set wins.
- **Error flag.** A transfer whose rd has its `pending` bit clear sets `wb_err`. The write still proceeds. `wb_err` clears only on reset.
- **Ignored inputs.** `issue_valid` with a pending rd has no effect; the requester retries.

## Timing
- **Reset values:** `rf_wea`=0, `rf_waddr`=0, `rf_wdata`=0, `pending`=0, `wb_err`=0, `last_grant`=M (A wins the first tie).
- While `reset` is high, `a_ready`, `m_ready` and `issue_ready` are 0.
- **Reset mid-operation:** an in-flight staged write is dropped (`rf_wea` is 0 in the following cycle) and all reservations are cleared.
- **Latency:**
  - A transfer in cycle t gives `rf_wea`=1 in cycle t+1.
  - The register file updates at the end of t+1.
  - `pending[rd]` reads 0 in t+2.
  - `issue_ready` for that rd is high from t+2.
- **Throughput:** one write per cycle. Under continuous dual requests, A and M alternate grants every cycle.

## Configuration
- **`REGFILE_WB_BYPASS_EN` defined:**
  - `fwdN_data` = `rf_wdata` when `rf_wea` is high and `rdN_addr`==`rf_waddr`; otherwise `rf_rNdata`.
  - This is combinational, with 0 cycles of added latency, so the value written in cycle t+1 is visible to reads in t+1.
  - `pending` timing is unchanged.
- **Undefined:** `fwdN_data` = `rf_rNdata`. The written value is visible from t+2.

## Test plan
- **Reset:** drive `reset`=1 for 2 cycles with all valids high → every ready=0, `rf_wea`=0, `pending`=16'h0000, `wb_err`=0. After release, A wins the first tie.
- **Single write:** issue rd=5 in cycle 0, giving `pending`=16'h0020. `a_valid` with rd=5, data=64'hDEAD_BEEF accepted in cycle 2 → `rf_wea`=1, `rf_waddr`=5 in cycle 3. `pending`=0 in cycle 4. `issue_ready` for rd=5 is low in cycles 1–3.
- **Contention:** reserve r1–r4. Hold both `a_valid` and `m_valid` for 4 cycles with distinct rds → grants A, M, A, M. `rf_waddr` matches each in the next cycle. The un-granted payload is held stable.
- **Error:** M writes rd=9 while `pending[9]`=0 → the write occurs and `wb_err`=1. `wb_err` stays 1 until reset.
- **Reset mid-flight:** a transfer is accepted in cycle t and `reset` is asserted in t+1 → `rf_wea`=0 in t+2 and `pending`=0.
- **Bypass** (macro defined): a transfer of rd=7 with data 64'h1234 in cycle t, and `rd0_addr`=7 in t+1 → `fwd0_data`=64'h1234 in t+1. Without the macro, `fwd0_data`=`rf_r0data`.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register-file write port (ALU pipe A vs. memory pipe M), with a registered write stage and a pending-write scoreboard.
// Optional macro REGFILE_WB_BYPASS_EN forwards the staged write onto the read data; the default build passes raw read data through.
module regfile_wb_arbiter #(
    parameter int DW = 64,
    parameter int AW = 4
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 a_valid,
    input  logic [AW-1:0]        a_rd,
    input  logic [DW-1:0]        a_data,
    output logic                 a_ready,

    input  logic                 m_valid,
    input  logic [AW-1:0]        m_rd,
    input  logic [DW-1:0]        m_data,
    output logic                 m_ready,

    input  logic                 issue_valid,
    input  logic [AW-1:0]        issue_rd,
    output logic                 issue_ready,
    output logic [(1<<AW)-1:0]   pending,

    output logic                 rf_wea,
    output logic [AW-1:0]        rf_waddr,
    output logic [DW-1:0]        rf_wdata,
    output logic                 wb_err,

    input  logic [AW-1:0]        rd0_addr,
    input  logic [AW-1:0]        rd1_addr,
    input  logic [DW-1:0]        rf_r0data,
    input  logic [DW-1:0]        rf_r1data,
    output logic [DW-1:0]        fwd0_data,
    output logic [DW-1:0]        fwd1_data
);

    localparam int NR = 1 << AW;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_M = 1'b1
    } grant_e;

    grant_e            last_grant_q;
    logic              rf_wea_q;
    logic [AW-1:0]     rf_waddr_q;
    logic [DW-1:0]     rf_wdata_q;
    logic [NR-1:0]     pending_q;
    logic [NR-1:0]     pending_d;
    logic              wb_err_q;

    logic              gnt_a;
    logic              gnt_m;
    logic              xfer;
    logic [AW-1:0]     win_rd;
    logic [DW-1:0]     win_data;
    logic              reserve;

    // Handshake: a requester transfers on valid & ready; ready is only raised for
    // a requester whose valid is high, and a losing requester holds valid/payload.
    always_comb begin
        gnt_a = 1'b0;
        gnt_m = 1'b0;
        if (!reset) begin
            if (a_valid && m_valid) begin
                gnt_a = (last_grant_q == GRANT_M);
                gnt_m = (last_grant_q == GRANT_A);
            end else begin
                gnt_a = a_valid;
                gnt_m = m_valid;
            end
        end
    end

    assign a_ready  = gnt_a;
    assign m_ready  = gnt_m;
    assign xfer     = gnt_a | gnt_m;
    assign win_rd   = gnt_m ? m_rd : a_rd;
    assign win_data = gnt_m ? m_data : a_data;

    // A register being released this cycle still reads as pending.
    assign issue_ready = !reset && !pending_q[issue_rd];
    assign reserve     = issue_valid && issue_ready;

    // Release first, then reserve, so a forced same-bit collision leaves it set.
    always_comb begin
        pending_d = pending_q;
        if (rf_wea_q) begin
            pending_d[rf_waddr_q] = 1'b0;
        end
        if (reserve) begin
            pending_d[issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= GRANT_M;
            rf_wea_q     <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            pending_q    <= '0;
            wb_err_q     <= 1'b0;
        end else begin
            rf_wea_q  <= xfer;
            pending_q <= pending_d;
            if (xfer) begin
                rf_waddr_q   <= win_rd;
                rf_wdata_q   <= win_data;
                last_grant_q <= gnt_m ? GRANT_M : GRANT_A;
                if (!pending_q[win_rd]) begin
                    wb_err_q <= 1'b1;
                end
            end
        end
    end

    assign rf_wea   = rf_wea_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign pending  = pending_q;
    assign wb_err   = wb_err_q;

`ifdef REGFILE_WB_BYPASS_EN
    always_comb begin
        fwd0_data = rf_r0data;
        fwd1_data = rf_r1data;
        if (rf_wea_q && (rd0_addr == rf_waddr_q)) begin
            fwd0_data = rf_wdata_q;
        end
        if (rf_wea_q && (rd1_addr == rf_waddr_q)) begin
            fwd1_data = rf_wdata_q;
        end
    end
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^{rd0_addr, rd1_addr};
    assign fwd0_data = rf_r0data;
    assign fwd1_data = rf_r1data;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, tie-break, single write latency, contention, error flag, reset mid-flight, bypass.
module tb_regfile_wb_arbiter;
    localparam int DW = 64;
    localparam int AW = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            a_valid, m_valid, issue_valid;
    logic [AW-1:0]   a_rd, m_rd, issue_rd, rd0_addr, rd1_addr;
    logic [DW-1:0]   a_data, m_data, rf_r0data, rf_r1data;
    logic            a_ready, m_ready, issue_ready, rf_wea, wb_err;
    logic [15:0]     pending;
    logic [AW-1:0]   rf_waddr;
    logic [DW-1:0]   rf_wdata, fwd0_data, fwd1_data;
    logic [DW-1:0]   exp_fwd0;

    int vectors = 0;
    int miscompares = 0;

    regfile_wb_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
        .m_valid(m_valid), .m_rd(m_rd), .m_data(m_data), .m_ready(m_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .pending(pending),
        .rf_wea(rf_wea), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_err(wb_err),
        .rd0_addr(rd0_addr), .rd1_addr(rd1_addr),
        .rf_r0data(rf_r0data), .rf_r1data(rf_r1data),
        .fwd0_data(fwd0_data), .fwd1_data(fwd1_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        a_valid = 1'b1; m_valid = 1'b1; issue_valid = 1'b1;
        a_rd = 4'd0; m_rd = 4'd0; issue_rd = 4'd0;
        a_data = '0; m_data = '0;
        rd0_addr = 4'd0; rd1_addr = 4'd0; rf_r0data = '0; rf_r1data = '0;

        // Reset held two cycles with all valids high
        tick(); tick();
        chk("rst_a_ready", a_ready, 0);
        chk("rst_m_ready", m_ready, 0);
        chk("rst_issue_ready", issue_ready, 0);
        chk("rst_rf_wea", rf_wea, 0);
        chk("rst_rf_waddr", rf_waddr, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        chk("rst_pending", pending, 16'h0000);
        chk("rst_wb_err", wb_err, 0);

        // Reserve r1, r2 then tie: A wins the first tie
        reset = 1'b0; a_valid = 1'b0; m_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 4'd1;
        #1 chk("res_r1_ready", issue_ready, 1);
        tick();
        issue_rd = 4'd2;
        #1 chk("res_r2_ready", issue_ready, 1);
        tick();
        issue_valid = 1'b0;
        a_valid = 1'b1; a_rd = 4'd1; a_data = 64'h11;
        m_valid = 1'b1; m_rd = 4'd2; m_data = 64'h22;
        #1;
        chk("tie_pending", pending, 16'h0006);
        chk("tie_a_ready", a_ready, 1);
        chk("tie_m_ready", m_ready, 0);
        tick();
        a_valid = 1'b0;
        #1;
        chk("tie2_m_ready", m_ready, 1);
        chk("tie2_a_ready", a_ready, 0);
        chk("tie2_rf_wea", rf_wea, 1);
        chk("tie2_rf_waddr", rf_waddr, 1);
        chk("tie2_rf_wdata", rf_wdata, 64'h11);
        tick();
        m_valid = 1'b0;
        #1;
        chk("tie3_rf_wea", rf_wea, 1);
        chk("tie3_rf_waddr", rf_waddr, 2);
        chk("tie3_rf_wdata", rf_wdata, 64'h22);
        chk("tie3_pending", pending, 16'h0004);
        chk("tie3_wb_err", wb_err, 0);
        tick();

        // Single write to r5: reserve cycle 0, write cycle 2
        issue_valid = 1'b1; issue_rd = 4'd5;
        #1;
        chk("sw0_pending", pending, 16'h0000);
        chk("sw0_rf_wea", rf_wea, 0);
        chk("sw0_issue_ready", issue_ready, 1);
        tick();
        #1;
        chk("sw1_pending", pending, 16'h0020);
        chk("sw1_issue_ready", issue_ready, 0);
        tick();
        issue_valid = 1'b0;
        a_valid = 1'b1; a_rd = 4'd5; a_data = 64'hDEAD_BEEF;
        #1;
        chk("sw2_a_ready", a_ready, 1);
        chk("sw2_issue_ready", issue_ready, 0);
        tick();
        a_valid = 1'b0;
        #1;
        chk("sw3_rf_wea", rf_wea, 1);
        chk("sw3_rf_waddr", rf_waddr, 5);
        chk("sw3_rf_wdata", rf_wdata, 64'hDEAD_BEEF);
        chk("sw3_pending", pending, 16'h0020);
        chk("sw3_issue_ready", issue_ready, 0);
        tick();
        chk("sw4_rf_wea", rf_wea, 0);
        chk("sw4_pending", pending, 16'h0000);
        chk("sw4_issue_ready", issue_ready, 1);
        chk("sw4_wb_err", wb_err, 0);

        // Error: M writes unreserved r9
        m_valid = 1'b1; m_rd = 4'd9; m_data = 64'h99;
        #1 chk("err_m_ready", m_ready, 1);
        tick();
        m_valid = 1'b0;
        #1;
        chk("err_rf_wea", rf_wea, 1);
        chk("err_rf_waddr", rf_waddr, 9);
        chk("err_rf_wdata", rf_wdata, 64'h99);
        chk("err_wb_err", wb_err, 1);
        tick();

        // Contention: reserve r1..r6, A sends r1,r3,r5 and M sends r2,r4
        for (int r = 1; r <= 6; r++) begin
            issue_valid = 1'b1; issue_rd = r[AW-1:0];
            #1 chk("cont_res_ready", issue_ready, 1);
            tick();
        end
        issue_valid = 1'b0;
        a_valid = 1'b1; a_rd = 4'd1; a_data = 64'hA1;
        m_valid = 1'b1; m_rd = 4'd2; m_data = 64'hB2;
        #1;
        chk("c0_pending", pending, 16'h007E);
        chk("c0_a_ready", a_ready, 1);
        chk("c0_m_ready", m_ready, 0);
        tick();
        a_rd = 4'd3; a_data = 64'hA3;
        #1;
        chk("c1_m_ready", m_ready, 1);
        chk("c1_a_ready", a_ready, 0);
        chk("c1_rf_wea", rf_wea, 1);
        chk("c1_rf_waddr", rf_waddr, 1);
        chk("c1_rf_wdata", rf_wdata, 64'hA1);
        tick();
        m_rd = 4'd4; m_data = 64'hB4;
        #1;
        chk("c2_a_ready", a_ready, 1);
        chk("c2_m_ready", m_ready, 0);
        chk("c2_rf_waddr", rf_waddr, 2);
        chk("c2_rf_wdata", rf_wdata, 64'hB2);
        chk("c2_pending", pending, 16'h007C);
        tick();
        a_rd = 4'd5; a_data = 64'hA5;
        #1;
        chk("c3_m_ready", m_ready, 1);
        chk("c3_a_ready", a_ready, 0);
        chk("c3_rf_waddr", rf_waddr, 3);
        chk("c3_rf_wdata", rf_wdata, 64'hA3);
        chk("c3_pending", pending, 16'h0078);
        tick();
        m_valid = 1'b0;
        #1;
        chk("c4_a_ready", a_ready, 1);
        chk("c4_rf_waddr", rf_waddr, 4);
        chk("c4_rf_wdata", rf_wdata, 64'hB4);
        chk("c4_pending", pending, 16'h0070);
        tick();
        a_valid = 1'b0;
        #1;
        chk("c5_rf_wea", rf_wea, 1);
        chk("c5_rf_waddr", rf_waddr, 5);
        chk("c5_rf_wdata", rf_wdata, 64'hA5);
        chk("c5_pending", pending, 16'h0060);
        chk("c5_wb_err", wb_err, 1);
        tick();

        // Issue against still-pending r6 is ignored
        issue_valid = 1'b1; issue_rd = 4'd6;
        #1;
        chk("ign_rf_wea", rf_wea, 0);
        chk("ign_pending", pending, 16'h0040);
        chk("ign_issue_ready", issue_ready, 0);
        tick();
        chk("ign2_pending", pending, 16'h0040);

        // Reset mid-flight
        issue_rd = 4'd10;
        #1 chk("rmf_res_ready", issue_ready, 1);
        tick();
        issue_valid = 1'b0;
        a_valid = 1'b1; a_rd = 4'd10; a_data = 64'hAA;
        #1;
        chk("rmf_a_ready", a_ready, 1);
        chk("rmf_pending", pending, 16'h0440);
        tick();
        reset = 1'b1; a_valid = 1'b0; m_valid = 1'b1; m_rd = 4'd6;
        #1;
        chk("rmf1_rf_wea", rf_wea, 1);
        chk("rmf1_rf_waddr", rf_waddr, 10);
        chk("rmf1_m_ready", m_ready, 0);
        tick();
        reset = 1'b0; m_valid = 1'b0;
        #1;
        chk("rmf2_rf_wea", rf_wea, 0);
        chk("rmf2_pending", pending, 16'h0000);
        chk("rmf2_wb_err", wb_err, 0);

        // Bypass of r7 write onto read port 0
        issue_valid = 1'b1; issue_rd = 4'd7;
        tick();
        issue_valid = 1'b0;
        a_valid = 1'b1; a_rd = 4'd7; a_data = 64'h1234;
        rd0_addr = 4'd7; rf_r0data = 64'hAAAA;
        rd1_addr = 4'd3; rf_r1data = 64'hBBBB;
        #1;
        chk("byp0_a_ready", a_ready, 1);
        chk("byp0_fwd0", fwd0_data, 64'hAAAA);
        tick();
        a_valid = 1'b0;
`ifdef REGFILE_WB_BYPASS_EN
        exp_fwd0 = 64'h1234;
`else
        exp_fwd0 = 64'hAAAA;
`endif
        #1;
        chk("byp1_rf_wea", rf_wea, 1);
        chk("byp1_rf_waddr", rf_waddr, 7);
        chk("byp1_fwd0", fwd0_data, exp_fwd0);
        chk("byp1_fwd1", fwd1_data, 64'hBBBB);
        tick();
        chk("byp2_fwd0", fwd0_data, 64'hAAAA);
        chk("byp2_pending", pending, 16'h0000);
        chk("byp2_wb_err", wb_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
